// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/sub/accumulate unit: op encoding,
// flagged result record and the saturation-limit helper.
package addsub_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ACC = 2'd2,
        CLR = 2'd3
    } op_t;

    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic             carry;
        logic             overflow;
    } res_t;

    // Clamp value for an n-bit result; neg selects the low limit.
    function automatic logic [MAX_W-1:0] sat_value(input logic is_signed,
                                                   input logic neg,
                                                   input int   n);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - n);
        if (is_signed) begin
            sat_value = neg ? (~(mask >> 1) & mask) : (mask >> 1);
        end else begin
            sat_value = neg ? '0 : mask;
        end
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational N+1-bit add/subtract with carry/borrow and overflow flags,
// followed by the optional saturation mux. ACC uses the accumulator as left operand.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int N      = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  op_t          op_i,
    input  logic         is_signed_i,
    input  logic         sat_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] acc_i,
    output logic [N-1:0] result_o,
    output logic         carry_o,
    output logic         overflow_o
);

    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N:0]   wide;
    logic         is_sub;
    logic         sgn_ovf;
    logic         ovf;

    always_comb begin
        x       = (op_i == ACC) ? acc_i : a_i;
        y       = (op_i == ACC) ? a_i   : b_i;
        is_sub  = (op_i == SUB);
        // Bit N is the carry for add and the borrow (x < y) for subtract.
        wide    = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        sgn_ovf = (is_sub ? (x[N-1] != y[N-1]) : (x[N-1] == y[N-1]))
                  && (wide[N-1] != x[N-1]);
        ovf     = is_signed_i ? sgn_ovf : wide[N];

        result_o   = wide[N-1:0];
        carry_o    = wide[N];
        overflow_o = ovf;

        if (SAT_EN && sat_i && ovf) begin
            result_o = N'(sat_value(is_signed_i, is_signed_i ? x[N-1] : is_sub, N));
        end

        if (op_i == CLR) begin
            result_o   = '0;
            carry_o    = 1'b0;
            overflow_o = 1'b0;
        end
    end

endmodule

// File: rtl/addsub_acc_pipe.sv
// Pipelined add/sub/accumulate unit: stage 1 computes, later stages delay; latency STAGES.
// One global enable (!out_valid | out_ready) advances or freezes every stage and in_ready.
module addsub_acc_pipe
    import addsub_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2,
    parameter bit SAT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  op_t          op,
    input  logic         is_signed,
    input  logic         sat,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "addsub_acc_pipe: STAGES must be 1..4");
    end
    if (N < 2 || N > MAX_W) begin : g_bad_width
        $fatal(1, "addsub_acc_pipe: N must be 2..64");
    end

    typedef struct packed {
        logic [N-1:0] result;
        logic         carry;
        logic         overflow;
    } beat_t;

    logic [STAGES-1:0] valid_q, valid_d;
    beat_t             pay_q [STAGES];
    beat_t             pay_d [STAGES];
    logic [N-1:0]      acc_q, acc_d;
    beat_t             core_res;
    logic              en;
    logic              accept;

    addsub_core #(.N(N), .SAT_EN(SAT_EN)) u_core (
        .op_i        (op),
        .is_signed_i (is_signed),
        .sat_i       (sat),
        .a_i         (a),
        .b_i         (b),
        .acc_i       (acc_q),
        .result_o    (core_res.result),
        .carry_o     (core_res.carry),
        .overflow_o  (core_res.overflow)
    );

    always_comb begin
        en      = !valid_q[STAGES-1] || out_ready;
        accept  = in_valid && en;
        valid_d = valid_q;
        pay_d   = pay_q;
        acc_d   = acc_q;
        if (en) begin
            valid_d[0] = in_valid;
            if (accept) begin
                pay_d[0] = core_res;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                pay_d[i]   = pay_q[i-1];
            end
        end
        // The accumulator follows accepted beats only, so a held beat never double-counts.
        if (accept && (op == ACC || op == CLR)) begin
            acc_d = core_res.result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            acc_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            acc_q   <= acc_d;
            pay_q   <= pay_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];
    assign result    = pay_q[STAGES-1].result;
    assign carry     = pay_q[STAGES-1].carry;
    assign overflow  = pay_q[STAGES-1].overflow;

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Directed N=8 checks plus randomized N=32 sweep over STAGES=1..4 against an arithmetic model.
module tb_addsub_acc_pipe;
    import addsub_pkg::*;

    localparam int S8 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=8 directed instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, is_signed8, sat8, carry8, ovf8;
    op_t        op8;
    logic [7:0] a8, b8, result8;

    addsub_acc_pipe #(.N(8), .STAGES(S8), .SAT_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .is_signed(is_signed8), .sat(sat8), .a(a8), .b(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .carry(carry8), .overflow(ovf8)
    );

    // N=32 sweep instances, index g has STAGES=g+1
    logic        rv [4];
    logic        rirdy [4];
    logic        rov [4];
    logic        rordy [4];
    logic        rsg [4];
    logic        rst_sat [4];
    logic        rc [4];
    logic        ro [4];
    op_t         rop [4];
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    logic [31:0] rres [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        addsub_acc_pipe #(.N(32), .STAGES(g + 1), .SAT_EN(1'b1)) u_dut (
            .clk(clk), .rst(rst), .in_valid(rv[g]), .in_ready(rirdy[g]), .op(rop[g]),
            .is_signed(rsg[g]), .sat(rst_sat[g]), .a(ra[g]), .b(rb[g]), .out_valid(rov[g]),
            .out_ready(rordy[g]), .result(rres[g]), .carry(rc[g]), .overflow(ro[g])
        );
    end

    res_t   q8[$];
    res_t   qr[$];
    longint m_acc8;
    longint m_accr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mathematical reference: exact integer sum/difference, then range tests.
    function automatic res_t model(input op_t o, input bit sg, input bit st,
                                   input longint a, input longint b, input longint acc, input int n);
        res_t   r;
        longint m, h, x, y, u, sx, sy, t;
        r = '0;
        if (o == CLR) return r;
        m = longint'(1) << n;
        h = m / 2;
        x = (o == ACC) ? acc : a;
        y = (o == ACC) ? a : b;
        if (o == SUB) begin
            u = x - y;
            r.carry = (x < y);
        end else begin
            u = x + y;
            r.carry = (u >= m);
        end
        u  = ((u % m) + m) % m;
        sx = (x >= h) ? x - m : x;
        sy = (y >= h) ? y - m : y;
        t  = (o == SUB) ? sx - sy : sx + sy;
        r.overflow = sg ? (t > h - 1 || t < -h) : r.carry;
        if (st && r.overflow) begin
            if (sg) u = (t > h - 1) ? h - 1 : h;
            else    u = (o == SUB) ? 0 : m - 1;
        end
        r.result = u;
        return r;
    endfunction

    task automatic step8(input logic v, input op_t o, input logic sg, input logic st,
                         input logic [7:0] a, input logic [7:0] b, input logic ordy);
        res_t e;
        @(negedge clk);
        in_valid8 = v; op8 = o; is_signed8 = sg; sat8 = st; a8 = a; b8 = b; out_ready8 = ordy;
        #1;
        if (out_valid8 && out_ready8) begin
            check("n8_unexpected_beat", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("n8_beat", {54'd0, carry8, ovf8, result8},
                      {54'd0, e.carry, e.overflow, e.result[7:0]});
            end
        end
        if (in_valid8 && in_ready8) begin
            e = model(o, sg, st, longint'(a), longint'(b), m_acc8, 8);
            q8.push_back(e);
            if (o == ACC || o == CLR) m_acc8 = longint'(e.result);
        end
    endtask

    // Single beat with explicit latency and hard expected values.
    task automatic lat8(input string tag, input op_t o, input logic sg, input logic st,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic eo);
        @(negedge clk);
        in_valid8 = 1'b1; op8 = o; is_signed8 = sg; sat8 = st; a8 = a; b8 = b; out_ready8 = 1'b1;
        for (int i = 1; i <= S8; i++) begin
            @(negedge clk);
            in_valid8 = 1'b0;
            #1;
            if (i < S8) check({tag, "_early"}, 64'(out_valid8), 64'd0);
        end
        check({tag, "_valid"}, 64'(out_valid8), 64'd1);
        check(tag, {54'd0, carry8, ovf8, result8}, {54'd0, ec, eo, er});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic stepr(input int k, input logic v, input logic ordy);
        res_t e;
        @(negedge clk);
        rv[k] = v; rop[k] = op_t'($urandom_range(0, 3)); rsg[k] = 1'($urandom_range(0, 1));
        rst_sat[k] = 1'($urandom_range(0, 1)); ra[k] = pick(); rb[k] = pick(); rordy[k] = ordy;
        #1;
        if (rov[k] && rordy[k]) begin
            check("n32_unexpected_beat", 64'(qr.size() > 0), 64'd1);
            if (qr.size() > 0) begin
                e = qr.pop_front();
                check("n32_beat", {30'd0, rc[k], ro[k], rres[k]},
                      {30'd0, e.carry, e.overflow, e.result[31:0]});
            end
        end
        if (rv[k] && rirdy[k]) begin
            e = model(rop[k], rsg[k], rst_sat[k], longint'(ra[k]), longint'(rb[k]), m_accr, 32);
            qr.push_back(e);
            if (rop[k] == ACC || rop[k] == CLR) m_accr = longint'(e.result);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; op8 = ADD; is_signed8 = 1'b0; sat8 = 1'b0; a8 = '0; b8 = '0;
        out_ready8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rv[k] = 1'b0; rop[k] = ADD; rsg[k] = 1'b0; rst_sat[k] = 1'b0;
            ra[k] = '0; rb[k] = '0; rordy[k] = 1'b1;
        end
        m_acc8 = 0;
        m_accr = 0;

        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid8), 64'd0);
        check("rst_outputs", {54'd0, carry8, ovf8, result8}, 64'd0);
        check("rst_acc", 64'(dut8.acc_q), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready8), 64'd1);

        lat8("add_u_wrap", ADD, 1'b0, 1'b0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b1);
        lat8("add_u_sat",  ADD, 1'b0, 1'b1, 8'd200, 8'd100, 8'd255, 1'b1, 1'b1);
        lat8("sub_s_wrap", SUB, 1'b1, 1'b0, 8'h80, 8'd1, 8'h7F, 1'b0, 1'b1);
        lat8("sub_s_sat",  SUB, 1'b1, 1'b1, 8'h80, 8'd1, 8'h80, 1'b0, 1'b1);
        lat8("sub_u_sat",  SUB, 1'b0, 1'b1, 8'd3, 8'd5, 8'd0, 1'b1, 1'b1);

        // CLR then three back-to-back accumulates
        step8(1'b1, CLR, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) step8(1'b1, ACC, 1'b0, 1'b0, 8'd10, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) step8(1'b0, ADD, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        check("acc_after_three", 64'(dut8.acc_q), 64'd30);

        // Fill the pipe with out_ready low, then hold for five cycles
        step8(1'b1, ADD, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
        step8(1'b1, ADD, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step8(1'b1, ACC, 1'b0, 1'b0, 8'd5, 8'd0, 1'b0);
            check("stall_in_ready", 64'(in_ready8), 64'd0);
            check("stall_frozen", {55'd0, out_valid8, result8}, {55'd0, 1'b1, 8'd1});
            check("stall_acc", 64'(dut8.acc_q), 64'd30);
        end
        step8(1'b1, ACC, 1'b0, 1'b0, 8'd5, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) step8(1'b0, ADD, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        check("stall_drained", 64'(q8.size()), 64'd0);
        check("acc_after_stall", 64'(dut8.acc_q), 64'd35);

        // Reset with two beats in flight
        step8(1'b1, ADD, 1'b0, 1'b0, 8'd3, 8'd4, 1'b1);
        step8(1'b1, ADD, 1'b0, 1'b0, 8'd5, 8'd6, 1'b1);
        @(negedge clk);
        in_valid8 = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid8), 64'd0);
        check("midrst_acc", 64'(dut8.acc_q), 64'd0);
        q8.delete();
        m_acc8 = 0;
        rst = 1'b0;
        lat8("post_rst_add", ADD, 1'b0, 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);

        // Randomized sweep, STAGES = 1..4 at N=32
        for (int k = 0; k < 4; k++) begin
            qr.delete();
            m_accr = 0;
            for (int i = 0; i < 300; i++) begin
                stepr(k, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7));
            end
            for (int i = 0; i < k + 4; i++) stepr(k, 1'b0, 1'b1);
            check("n32_drained", 64'(qr.size()), 64'd0);
            rv[k] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
